// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//
// Main control FSM for the multi-cycle MIPS datapath. Sequences fetch,
// decode, execute, memory access and writeback for R-type, lw, sw, beq
// and j instructions. Moore machine: every control output is a pure
// function of the current state.
//
// Ports:
//   clk            system clock, rising-edge active
//   reset          synchronous active-high reset (to FETCH, clears illegal_op)
//   opcode         instruction[31:26] from the instruction register
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by ALU zero (branch)
//   i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       instruction register load
//   mem_to_reg     register write data: 0 = ALUOut, 1 = MDR
//   reg_dst        destination register: 0 = rt, 1 = rd
//   reg_write      register file write strobe
//   alu_src_a      ALU A: 0 = PC, 1 = reg A
//   alu_src_b      ALU B: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op         00 = add, 01 = sub, 10 = use funct
//   pc_source      00 = ALU result, 01 = ALUOut, 10 = jump target
//   state          current state encoding (debug visibility)
//   illegal_op     sticky flag: unsupported opcode was decoded
module mips_multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; opcode is only looked at in DECODE and MEMADR,
  // where the instruction register is guaranteed stable.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else begin
          // Unsupported opcode: abandon the instruction, flag it sticky.
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RTWB;
      // MEMWB, MEMWR, RTWB, BRANCH, JUMP and unused encodings return to FETCH.
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode from state only; anything not set below stays 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench for mips_multicycle_control: directed instruction sequences,
// expected (state, illegal_op) pairs queued when an instruction is launched
// and popped one per clock as the FSM steps.
module tb_mips_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Control word order:
  // pc_write pc_write_cond i_or_d mem_read mem_write ir_write
  // mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op pc_source
  function automatic logic [15:0] ctrl_of(input logic [3:0] s);
    case (s)
      4'd0:    return 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
      4'd1:    return 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
      4'd2:    return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
      4'd3:    return 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
      4'd4:    return 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
      4'd5:    return 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
      4'd6:    return 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
      4'd7:    return 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
      4'd8:    return 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
      4'd9:    return 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic ill);
    exp_t e;
    e.st  = st;
    e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Pop one expectation per clock, compare on the falling edge, then
  // advance to just after the next rising edge.
  task automatic drain(input string tag);
    exp_t e;
    logic [15:0] obs_ctrl;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      obs_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source};
      n_cmp++;
      assert (state === e.st) else begin
        n_fail++;
        $error("FAIL %s state: observed %0d expected %0d", tag, state, e.st);
      end
      n_cmp++;
      assert (obs_ctrl === ctrl_of(e.st)) else begin
        n_fail++;
        $error("FAIL %s ctrl(st=%0d): observed %b expected %b", tag, e.st, obs_ctrl,
               ctrl_of(e.st));
      end
      n_cmp++;
      assert (illegal_op === e.ill) else begin
        n_fail++;
        $error("FAIL %s illegal_op: observed %b expected %b", tag, illegal_op, e.ill);
      end
      n_cmp++;
      assert (!(mem_read && mem_write) && !(reg_write && mem_write)) else begin
        n_fail++;
        $error("FAIL %s strobe_excl: observed rd=%b wr=%b rw=%b expected exclusive",
               tag, mem_read, mem_write, reg_write);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First cycle after reset shows FETCH, flag clear.
    push(4'd0, 1'b0);
    drain("reset");
    // drain advanced one edge into DECODE with opcode 0: finish R-type.
    push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd7, 1'b0);
    drain("rtype0");

    opcode = 6'h23;
    push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd2, 1'b0);
    push(4'd3, 1'b0); push(4'd4, 1'b0);
    drain("lw");

    opcode = 6'h2B;
    push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd5, 1'b0);
    drain("sw");

    opcode = 6'h00;
    push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd6, 1'b0); push(4'd7, 1'b0);
    drain("rtype");

    opcode = 6'h04;
    push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd8, 1'b0);
    drain("beq");

    opcode = 6'h02;
    push(4'd0, 1'b0); push(4'd1, 1'b0); push(4'd9, 1'b0);
    drain("j");

    // Unsupported opcode: back to FETCH after DECODE, flag rises on that edge.
    opcode = 6'h3F;
    push(4'd0, 1'b0); push(4'd1, 1'b0);
    drain("illegal");

    // Flag stays set while later instructions run normally.
    opcode = 6'h04;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd8, 1'b1);
    drain("beq_sticky");

    opcode = 6'h2B;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd2, 1'b1); push(4'd5, 1'b1);
    drain("sw_sticky");

    // lw interrupted by reset while in MEMRD.
    opcode = 6'h23;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd2, 1'b1);
    drain("lw_pre_rst");
    reset = 1'b1;
    push(4'd3, 1'b1);
    drain("memrd_rst");
    reset = 1'b0;
    push(4'd0, 1'b0);
    drain("after_rst");

    // Normal operation resumes from the reset FETCH (already past its edge).
    push(4'd1, 1'b0); push(4'd2, 1'b0); push(4'd3, 1'b0); push(4'd4, 1'b0);
    push(4'd0, 1'b0);
    drain("lw_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
